// File: rtl/exec_controller_pkg.sv
// Shared encodings for the run/halt sequencer: FSM states, halt causes, default widths.
// Pure declarations; no timing or flow-control behaviour.
package exec_ctrl_pkg;

    localparam int DEF_PC_W  = 32;
    localparam int DEF_CNT_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [2:0] HC_NONE    = 3'd0;
    localparam logic [2:0] HC_INVALID = 3'd1;
    localparam logic [2:0] HC_BP      = 3'd2;
    localparam logic [2:0] HC_WDT     = 3'd3;
    localparam logic [2:0] HC_STOP    = 3'd4;
    localparam logic [2:0] HC_STEP    = 3'd5;

    // Halt reason while running; stop is the fallback because it is the only other halt source.
    function automatic logic [2:0] run_halt_cause(input logic invalid, input logic bp, input logic wdt);
        if (invalid)  return HC_INVALID;
        else if (bp)  return HC_BP;
        else if (wdt) return HC_WDT;
        else          return HC_STOP;
    endfunction

endpackage

// File: rtl/exec_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Count updates one cycle after inc/clr; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/exec_controller.sv
// Run/halt sequencer for the single-cycle core: gates PC update and architectural commit.
// pc_en/commit_en are combinational from state and inputs; state changes on the next edge.
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             invalid_inst,
    input  logic [CNT_W-1:0] wdt_limit,
    output logic             pc_en,
    output logic             commit_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    logic             bp_mask;
    logic             run_st;
    logic             step_st;
    logic             bp_hit;
    logic             wdt_hit;
    logic             halt_now;
    logic             start_run;
    logic             cnt_zero;
    logic [CNT_W-1:0] run_cnt;
    logic [1:0]       state_nxt;
    logic [2:0]       cause_nxt;
    logic             mask_nxt;

    assign run_st   = (state == ST_RUN);
    assign step_st  = (state == ST_STEP);
    assign halted   = (state == ST_HALT);
    assign bp_hit   = bp_en & ~bp_mask & (pc == bp_addr);
    assign wdt_hit  = (wdt_limit != '0) & (run_cnt == wdt_limit);
    assign halt_now = run_st & (invalid_inst | bp_hit | wdt_hit | stop);

    assign commit_en = ~clear & ((run_st & ~halt_now) | (step_st & ~invalid_inst));
    assign pc_en     = commit_en;

    // In HALT a pending step outranks start, so start only launches RUN without step.
    assign start_run = start & ((state == ST_IDLE) | (halted & ~step));
    assign cnt_zero  = clear | ((state == ST_IDLE) & start);

    always_comb begin
        state_nxt = state;
        cause_nxt = halt_cause;
        mask_nxt  = bp_mask;
        if (run_st || step_st) begin
            mask_nxt = 1'b0;
        end
        if (clear) begin
            state_nxt = ST_IDLE;
            cause_nxt = HC_NONE;
            mask_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)     state_nxt = ST_RUN;
                    else if (step) state_nxt = ST_STEP;
                end
                ST_RUN: begin
                    if (halt_now) begin
                        state_nxt = ST_HALT;
                        cause_nxt = run_halt_cause(invalid_inst, bp_hit, wdt_hit);
                    end
                end
                ST_STEP: begin
                    state_nxt = ST_HALT;
                    cause_nxt = invalid_inst ? HC_INVALID : HC_STEP;
                end
                default: begin
                    // Mask the breakpoint for one cycle so resuming at the bp PC makes progress.
                    if (step || start) begin
                        state_nxt = step ? ST_STEP : ST_RUN;
                        cause_nxt = HC_NONE;
                        mask_nxt  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            halt_cause <= HC_NONE;
            bp_mask    <= 1'b0;
        end else begin
            state      <= state_nxt;
            halt_cause <= cause_nxt;
            bp_mask    <= mask_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_st | step_st),
        .clr   (cnt_zero),
        .count (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit_en),
        .clr   (cnt_zero),
        .count (retired_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_st & ~halt_now),
        .clr   (clear | start_run),
        .count (run_cnt)
    );

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller: inputs change on the falling edge, outputs are checked 1ns later.
module tb_exec_controller;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, step, clear, bp_en, invalid_inst;
    logic [PC_W-1:0]  bp_addr, pc;
    logic [CNT_W-1:0] wdt_limit;
    logic             pc_en, commit_en, halted;
    logic [1:0]       state;
    logic [2:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt, retired_cnt;

    int vectors = 0;
    int errs    = 0;

    exec_controller #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .step         (step),
        .clear        (clear),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .pc           (pc),
        .invalid_inst (invalid_inst),
        .wdt_limit    (wdt_limit),
        .pc_en        (pc_en),
        .commit_en    (commit_en),
        .state        (state),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .cycle_cnt    (cycle_cnt),
        .retired_cnt  (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; the bench plays the core and advances pc when pc_en was high before the edge.
    task automatic cyc();
        logic en;
        #1;
        en = pc_en;
        @(posedge clk);
        @(negedge clk);
        if (en) pc = pc + 1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        pc = '0;
    endtask

    initial begin
        rst = 1'b0;
        start = 0; stop = 0; step = 0; clear = 0; bp_en = 0; invalid_inst = 0;
        bp_addr = '0; pc = '0; wdt_limit = '0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_retired", retired_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: run pc 0..9, stop on the 11th RUN cycle
        start = 1'b1;
        #1 chk("t1_idle_no_commit", pc_en, 0);
        cyc();
        start = 1'b0;
        chk("t1_run", state, 1);
        for (int i = 0; i < 10; i++) cyc();
        chk("t1_pc_progress", pc, 10);
        stop = 1'b1;
        #1 chk("t1_stop_pc_en", pc_en, 0);
        cyc();
        stop = 1'b0;
        chk("t1_halt", state, 3);
        chk("t1_halted", halted, 1);
        chk("t1_cause", halt_cause, 4);
        chk("t1_retired", retired_cnt, 10);
        chk("t1_cycle", cycle_cnt, 11);

        // 2: breakpoint at 5, then resume executes the instruction at 5
        do_clear();
        chk("t2_clear_idle", state, 0);
        bp_en = 1'b1; bp_addr = 5;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        #1 chk("t2_bp_pc_en", pc_en, 0);
        cyc();
        chk("t2_halt", state, 3);
        chk("t2_cause", halt_cause, 2);
        chk("t2_retired", retired_cnt, 5);
        chk("t2_pc_held", pc, 5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t2_resume_run", state, 1);
        chk("t2_resume_cause", halt_cause, 0);
        #1 chk("t2_commit_at_bp", commit_en, 1);
        cyc();
        chk("t2_no_rehalt", state, 1);
        chk("t2_retired6", retired_cnt, 6);

        // 3: stop, then three single steps
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t3_halt", state, 3);
        chk("t3_retired_base", retired_cnt, 6);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            chk("t3_in_step", state, 2);
            chk("t3_step_cause0", halt_cause, 0);
            #1 chk("t3_step_commit", commit_en, 1);
            cyc();
            chk("t3_back_halt", state, 3);
            chk("t3_cause5", halt_cause, 5);
            #1 chk("t3_halt_no_commit", commit_en, 0);
        end
        chk("t3_retired9", retired_cnt, 9);

        // 4: invalid instruction at pc=3, then resume with it still flagged
        bp_en = 1'b0;
        do_clear();
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        invalid_inst = 1'b1;
        #1 chk("t4_inv_no_commit", commit_en, 0);
        cyc();
        chk("t4_halt", state, 3);
        chk("t4_cause", halt_cause, 1);
        chk("t4_retired", retired_cnt, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_resume_run", state, 1);
        #1 chk("t4_resume_no_commit", pc_en, 0);
        cyc();
        chk("t4_rehalt", state, 3);
        chk("t4_recause", halt_cause, 1);
        chk("t4_retired_same", retired_cnt, 3);
        invalid_inst = 1'b0;

        // 5: watchdog after 4 run cycles, then start+stop together
        do_clear();
        wdt_limit = 4;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        #1 chk("t5_wdt_no_commit", pc_en, 0);
        cyc();
        chk("t5_halt", state, 3);
        chk("t5_cause", halt_cause, 3);
        chk("t5_retired", retired_cnt, 4);
        chk("t5_cycle", cycle_cnt, 5);
        wdt_limit = '0;
        start = 1'b1;
        cyc();
        chk("t5_resume_run", state, 1);
        stop = 1'b1;
        #1 chk("t5_stop_no_commit", pc_en, 0);
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t5_stop_wins", state, 3);
        chk("t5_stop_cause", halt_cause, 4);
        chk("t5_retired_same", retired_cnt, 4);

        // 6: asynchronous reset mid-RUN, then clear from HALT
        do_clear();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        chk("t6_pre_retired", retired_cnt, 2);
        #2 rst = 1'b0;
        #1;
        chk("t6_arst_state", state, 0);
        chk("t6_arst_pc_en", pc_en, 0);
        chk("t6_arst_cycle", cycle_cnt, 0);
        chk("t6_arst_retired", retired_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        pc = '0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t6_halt", state, 3);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t6_clr_state", state, 0);
        chk("t6_clr_cause", halt_cause, 0);
        chk("t6_clr_cycle", cycle_cnt, 0);
        chk("t6_clr_retired", retired_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
